synth_env_ctrl: RTL

- Sequences the synth voice datapath.
- Accepts 16-bit command words from the SPI slave (note-on with velocity, note-off, rate/level config).
- Runs an ADSR state machine that produces the 10-bit amplitude word for the Amp stage and a one-cycle retrigger pulse for the oscillator/saw reset.
- Sits between the SPI register and the Synth voice in the top level, replacing the ad-hoc "data changed" gate logic.

---
 rtl/synth_pkg.sv | 41 ++++
 rtl/synth_env_ctrl_if.sv | 12 +
 rtl/env_tick_gen.sv | 27 ++
 rtl/synth_env_ctrl.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/synth_pkg.sv
// synth_pkg: shared opcodes, config selects, envelope state codes, command layout and reset defaults.
package synth_pkg;

   localparam int unsigned CMD_W   = 16;
   localparam int unsigned VALUE_W = 10;

   localparam int unsigned DEF_ATTACK_RATE  = 8;
   localparam int unsigned DEF_DECAY_RATE   = 4;
   localparam int unsigned DEF_SUSTAIN_LVL  = 512;
   localparam int unsigned DEF_RELEASE_RATE = 2;

   typedef enum logic [1:0] {
      OP_NOP      = 2'd0,
      OP_NOTE_ON  = 2'd1,
      OP_NOTE_OFF = 2'd2,
      OP_CONFIG   = 2'd3
   } opcode_e;

   typedef enum logic [1:0] {
      CFG_ATTACK  = 2'd0,
      CFG_DECAY   = 2'd1,
      CFG_SUSTAIN = 2'd2,
      CFG_RELEASE = 2'd3
   } cfg_sel_e;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ATTACK  = 3'd1,
      ST_DECAY   = 3'd2,
      ST_SUSTAIN = 3'd3,
      ST_RELEASE = 3'd4
   } env_state_e;

   typedef struct packed {
      opcode_e              op;
      cfg_sel_e             sel;
      logic [1:0]           rsvd;
      logic [VALUE_W-1:0]   value;
   } cmd_t;

endpackage

// File: rtl/synth_env_ctrl_if.sv
// synth_env_ctrl_if: valid/ready command channel from the SPI register to the envelope controller.
interface synth_env_ctrl_if;
   import synth_pkg::*;

   logic [CMD_W-1:0] cmd_data;
   logic             cmd_valid;
   logic             cmd_ready;

   modport master (output cmd_data, output cmd_valid, input  cmd_ready);
   modport slave  (input  cmd_data, input  cmd_valid, output cmd_ready);

endinterface

// File: rtl/env_tick_gen.sv
// env_tick_gen: free-running prescaler, tick_c high on the last count of every TICK_DIV cycles.
module env_tick_gen #(
   parameter int unsigned TICK_DIV = 48000
) (
   input  logic clk,
   input  logic rst_n,
   output logic tick_c
);

   localparam int unsigned   CNT_W    = $clog2(TICK_DIV);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q + CNT_W'(1);
      if (cnt_q == CNT_LAST) cnt_d = '0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign tick_c = (cnt_q == CNT_LAST);

endmodule

// File: rtl/synth_env_ctrl.sv
// synth_env_ctrl: command decode and ADSR envelope sequencer for one synth voice.
// Build option SYNTH_ENV_LEGATO_EN: NOTE_ON on a sounding note continues from the current level.
module synth_env_ctrl
   import synth_pkg::*;
#(
   parameter int unsigned TICK_DIV = 48000,
   parameter int unsigned AMP_W    = 10
) (
   input  logic             clk,
   input  logic             rst_n,
   synth_env_ctrl_if.slave  cmd,
   output logic [AMP_W-1:0] amp_out,
   output logic             retrig,
   output logic             gate_out,
   output logic [2:0]       state_out
);

   logic             tick_c;
   logic             cmd_ready_q, cmd_ready_d;
   logic             dec_q, dec_d;
   cmd_t             cmd_q, cmd_d;
   env_state_e       state_q, state_d;
   logic [AMP_W-1:0] amp_q, amp_d;
   logic [AMP_W-1:0] peak_q, peak_d;
   logic [AMP_W-1:0] attack_q, attack_d;
   logic [AMP_W-1:0] decay_q, decay_d;
   logic [AMP_W-1:0] sustain_q, sustain_d;
   logic [AMP_W-1:0] release_q, release_d;
   logic             gate_q, gate_d;
   logic             retrig_q, retrig_d;

   logic [AMP_W-1:0] val_c, rate_val_c, target_c;
   logic [AMP_W:0]   attack_sum_c;
   logic             note_off_c, active_c, legal_c;
   logic             unused_c;

   function automatic logic [AMP_W-1:0] sat_add(input logic [AMP_W-1:0] a, input logic [AMP_W-1:0] b);
      logic [AMP_W:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[AMP_W] ? '1 : s[AMP_W-1:0];
   endfunction

   function automatic logic [AMP_W-1:0] sat_sub(input logic [AMP_W-1:0] a, input logic [AMP_W-1:0] b);
      return (a > b) ? (a - b) : '0;
   endfunction

   env_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
      .clk    (clk),
      .rst_n  (rst_n),
      .tick_c (tick_c)
   );

   assign val_c        = AMP_W'(cmd_q.value);
   assign rate_val_c   = (val_c == '0) ? AMP_W'(1) : val_c;
   assign target_c     = (sustain_q < peak_q) ? sustain_q : peak_q;
   assign attack_sum_c = {1'b0, amp_q} + {1'b0, attack_q};
   assign active_c     = (state_q == ST_ATTACK) || (state_q == ST_DECAY) || (state_q == ST_SUSTAIN);
   assign legal_c      = active_c || (state_q == ST_IDLE) || (state_q == ST_RELEASE);
   assign unused_c     = ^cmd_q.rsvd;

   // Handshake, command decode and per-tick envelope stepping.
   always_comb begin
      cmd_ready_d = 1'b1;
      dec_d       = 1'b0;
      cmd_d       = cmd_q;
      state_d     = state_q;
      amp_d       = amp_q;
      peak_d      = peak_q;
      attack_d    = attack_q;
      decay_d     = decay_q;
      sustain_d   = sustain_q;
      release_d   = release_q;
      gate_d      = gate_q;
      retrig_d    = 1'b0;
      note_off_c  = 1'b0;

      if (cmd.cmd_valid && cmd_ready_q) begin
         cmd_d       = cmd_t'(cmd.cmd_data);
         dec_d       = 1'b1;
         cmd_ready_d = 1'b0;
      end

      if (dec_q) begin
         // A decode cycle owns the envelope; a coinciding tick step is dropped.
         unique case (cmd_q.op)
            OP_NOP: ;
            OP_NOTE_ON: begin
               peak_d = val_c;
               if (val_c == '0) begin
                  note_off_c = 1'b1;
               end else begin
                  gate_d  = 1'b1;
                  state_d = ST_ATTACK;
`ifdef SYNTH_ENV_LEGATO_EN
                  if (!active_c) retrig_d = 1'b1;
                  if (state_q == ST_IDLE) amp_d = '0;
`else
                  retrig_d = 1'b1;
                  amp_d    = '0;
`endif
               end
            end
            OP_NOTE_OFF: note_off_c = 1'b1;
            OP_CONFIG: begin
               unique case (cmd_q.sel)
                  CFG_ATTACK:  attack_d  = rate_val_c;
                  CFG_DECAY:   decay_d   = rate_val_c;
                  CFG_SUSTAIN: sustain_d = val_c;
                  CFG_RELEASE: release_d = rate_val_c;
               endcase
            end
         endcase
         if (note_off_c) begin
            gate_d = 1'b0;
            if (active_c) state_d = ST_RELEASE;
         end
      end else if (tick_c) begin
         case (state_q)
            ST_IDLE: amp_d = '0;
            ST_ATTACK: begin
               if (attack_sum_c >= {1'b0, peak_q}) begin
                  amp_d   = peak_q;
                  state_d = ST_DECAY;
               end else begin
                  amp_d = sat_add(amp_q, attack_q);
               end
            end
            ST_DECAY: begin
               // Snap once the next step would reach or pass the target.
               if (amp_q <= sat_add(target_c, decay_q)) begin
                  amp_d   = target_c;
                  state_d = ST_SUSTAIN;
               end else begin
                  amp_d = sat_sub(amp_q, decay_q);
               end
            end
            ST_SUSTAIN: ;
            ST_RELEASE: begin
               if (amp_q <= release_q) begin
                  amp_d   = '0;
                  state_d = ST_IDLE;
               end else begin
                  amp_d = sat_sub(amp_q, release_q);
               end
            end
            default: ;
         endcase
      end

      if (!legal_c) begin
         state_d = ST_IDLE;
         amp_d   = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cmd_ready_q <= 1'b1;
         dec_q       <= 1'b0;
         cmd_q       <= cmd_t'('0);
         state_q     <= ST_IDLE;
         amp_q       <= '0;
         peak_q      <= '0;
         attack_q    <= AMP_W'(DEF_ATTACK_RATE);
         decay_q     <= AMP_W'(DEF_DECAY_RATE);
         sustain_q   <= AMP_W'(DEF_SUSTAIN_LVL);
         release_q   <= AMP_W'(DEF_RELEASE_RATE);
         gate_q      <= 1'b0;
         retrig_q    <= 1'b0;
      end else begin
         cmd_ready_q <= cmd_ready_d;
         dec_q       <= dec_d;
         cmd_q       <= cmd_d;
         state_q     <= state_d;
         amp_q       <= amp_d;
         peak_q      <= peak_d;
         attack_q    <= attack_d;
         decay_q     <= decay_d;
         sustain_q   <= sustain_d;
         release_q   <= release_d;
         gate_q      <= gate_d;
         retrig_q    <= retrig_d;
      end
   end

   assign cmd.cmd_ready = cmd_ready_q;
   assign amp_out       = amp_q;
   assign retrig        = retrig_q;
   assign gate_out      = gate_q;
   assign state_out     = state_q;

endmodule
